// File: rtl/graphics_pkg.sv
// graphics_pkg: shared vertex/triangle types and lane constants for the geometry pipeline
package graphics_pkg;
  typedef logic [3:0][31:0] vertex_t;
  typedef logic [2:0][3:0][31:0] triangle_t;
  localparam int VERTS_PER_TRI = 3;
  localparam int X = 0;
  localparam int Y = 1;
  localparam int Z = 2;
  localparam int W = 3;
endpackage

// File: rtl/triangle_assemble.sv
// triangle_assemble: regroups the clipped vertex stream into triangles; tri_id_out via TRIANGLE_ASSEMBLE_TRI_ID_EN
module triangle_assemble
  import graphics_pkg::*;
#(
  parameter int ID_WIDTH = 16
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  logic      valid_in,
  output logic      ready_out,
  input  vertex_t   vertex_in,
  input  logic      flush_in,
  output logic      valid_out,
  input  logic      ready_in,
  output triangle_t triangle_out
`ifdef TRIANGLE_ASSEMBLE_TRI_ID_EN
  ,
  output logic [ID_WIDTH-1:0] tri_id_out
`endif
);
  localparam logic [1:0] COLLECT0 = 2'd0;
  localparam logic [1:0] COLLECT1 = 2'd1;
  localparam logic [1:0] COLLECT2 = 2'(VERTS_PER_TRI - 1);
  logic [1:0] count_q, count_d;
  vertex_t slot0_q, slot1_q;
  triangle_t tri_q;
  logic valid_q, valid_d, accept, complete;
`ifdef TRIANGLE_ASSEMBLE_TRI_ID_EN
  logic [ID_WIDTH-1:0] id_q, tri_id_q;
  assign tri_id_out = tri_id_q;
`endif
  // Only the completing vertex waits on a stalled output register.
  assign ready_out = rst_n_in && !flush_in && !(count_q == COLLECT2 && valid_q && !ready_in);
  assign accept = valid_in && ready_out;
  assign complete = accept && count_q == COLLECT2;
  assign valid_out = valid_q;
  assign triangle_out = tri_q;
  always_comb begin
    count_d = flush_in ? COLLECT0 : !accept ? count_q : complete ? COLLECT0 : count_q + 2'd1;
    valid_d = complete || (valid_q && !ready_in);
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= COLLECT0;
      slot0_q <= '0;
      slot1_q <= '0;
      valid_q <= 1'b0;
      tri_q   <= '0;
`ifdef TRIANGLE_ASSEMBLE_TRI_ID_EN
      id_q     <= '0;
      tri_id_q <= '0;
`endif
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      if (accept && count_q == COLLECT0) slot0_q <= vertex_in;
      if (accept && count_q == COLLECT1) slot1_q <= vertex_in;
      if (complete) begin
        tri_q <= {vertex_in, slot1_q, slot0_q};
`ifdef TRIANGLE_ASSEMBLE_TRI_ID_EN
        tri_id_q <= id_q;
        id_q     <= id_q + 1'b1;
`endif
      end
    end
  end
endmodule
